// File: rtl/instruction_fetch_if.sv
// Instruction ROM bus: byte address and read/write control from the fetch unit,
// combinational read data back from the ROM.
interface instruction_fetch_if;
  logic [31:0] rom_address;
  logic        rom_rw;
  logic [31:0] rom_data;

  modport master (output rom_address, output rom_rw, input rom_data);
  modport slave  (input rom_address, input rom_rw, output rom_data);
endinterface

// File: rtl/instruction_fetch.sv
// Fetch-side initiator for the multicycle CPU: owns the PC, reads a big-endian
// word from the instruction ROM after a programmable wait and latches it into ir.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ROM_BYTES   = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       fetch_req,
  input  logic                       pc_write,
  input  logic [1:0]                 pc_src,
  input  logic [15:0]                branch_imm,
  input  logic [25:0]                jump_target,
  input  logic [31:0]                reg_target,
  instruction_fetch_if.master        rom,
  output logic [31:0]                pc,
  output logic [31:0]                pc_plus4,
  output logic [31:0]                ir,
  output logic                       ir_valid,
  output logic                       busy,
  output logic                       fault
);

  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_WAIT   = 1'b1;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam logic [32:0] ROM_LIMIT = 33'(ROM_BYTES);

  logic [0:0]  state;
  logic [3:0]  wait_cnt;
  logic [31:0] pc_next;
  logic [32:0] fetch_last;
  logic        fetch_legal;

  assign pc_plus4        = pc + 32'd4;
  assign rom.rom_address = pc;
  assign rom.rom_rw      = 1'b0;
  assign busy            = (state == ST_WAIT);

  // Last byte of the word computed one bit wider so a pc near 2^32 cannot wrap into range.
  assign fetch_last  = {1'b0, pc} + 33'd3;
  assign fetch_legal = (pc[1:0] == 2'b00) && (fetch_last < ROM_LIMIT);

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    pc_next = pc_plus4;
    case (pc_src)
      2'b00:   pc_next = pc_plus4;
      2'b01:   pc_next = pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
      2'b10:   pc_next = {pc_plus4[31:28], jump_target, 2'b00};
      default: pc_next = reg_target;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      pc       <= RESET_PC;
      ir       <= 32'd0;
      ir_valid <= 1'b0;
      fault    <= 1'b0;
    end else begin
      ir_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // pc_write outranks fetch_req; the dropped request must be re-issued.
          if (pc_write) begin
            pc <= pc_next;
          end else if (fetch_req && !fault) begin
            if (!fetch_legal) begin
              fault <= 1'b1;
            end else begin
              wait_cnt <= WAIT_LOAD;
              state    <= ST_WAIT;
            end
          end
        end
        default: begin
          // pc is frozen here so rom_address stays stable for the whole access.
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            ir       <= rom.rom_data;
            ir_valid <= 1'b1;
            state    <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: one instance with no wait states, one with
// three, both reading a byte-array ROM model that returns big-endian words.
module tb_instruction_fetch;

  logic clk;
  logic rst_n;

  logic        fr_a, pw_a, fr_b, pw_b;
  logic [1:0]  src_a, src_b;
  logic [15:0] bimm_a, bimm_b;
  logic [25:0] jt_a, jt_b;
  logic [31:0] rt_a, rt_b;
  logic [31:0] pc_a, pc4_a, ir_a, pc_b, pc4_b, ir_b;
  logic        irv_a, busy_a, fault_a, irv_b, busy_b, fault_b;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] rom_mem [256];

  instruction_fetch_if rom_a ();
  instruction_fetch_if rom_b ();

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    if (addr > 32'd252) return 32'hDEAD_BEEF;
    return {rom_mem[addr[7:0]], rom_mem[addr[7:0] + 8'd1],
            rom_mem[addr[7:0] + 8'd2], rom_mem[addr[7:0] + 8'd3]};
  endfunction

  assign rom_a.rom_data = rom_word(rom_a.rom_address);
  assign rom_b.rom_data = rom_word(rom_b.rom_address);

  instruction_fetch #(.RESET_PC(32'h0), .WAIT_CYCLES(0), .ROM_BYTES(256)) u_a (
    .clk(clk), .rst_n(rst_n), .fetch_req(fr_a), .pc_write(pw_a), .pc_src(src_a),
    .branch_imm(bimm_a), .jump_target(jt_a), .reg_target(rt_a), .rom(rom_a),
    .pc(pc_a), .pc_plus4(pc4_a), .ir(ir_a), .ir_valid(irv_a), .busy(busy_a), .fault(fault_a)
  );

  instruction_fetch #(.RESET_PC(32'h0), .WAIT_CYCLES(3), .ROM_BYTES(256)) u_b (
    .clk(clk), .rst_n(rst_n), .fetch_req(fr_b), .pc_write(pw_b), .pc_src(src_b),
    .branch_imm(bimm_b), .jump_target(jt_b), .reg_target(rt_b), .rom(rom_b),
    .pc(pc_b), .pc_plus4(pc4_b), .ir(ir_b), .ir_valid(irv_b), .busy(busy_b), .fault(fault_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pcw_a(input logic [1:0] s, input logic [31:0] v);
    src_a = s; rt_a = v; jt_a = v[25:0]; bimm_a = v[15:0]; pw_a = 1'b1;
    step();
    pw_a = 1'b0;
  endtask

  task automatic pcw_b(input logic [1:0] s, input logic [31:0] v);
    src_b = s; rt_b = v; jt_b = v[25:0]; bimm_b = v[15:0]; pw_b = 1'b1;
    step();
    pw_b = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i);
    rom_mem[0] = 8'h8C; rom_mem[1] = 8'h01; rom_mem[2] = 8'h00; rom_mem[3] = 8'h04;

    rst_n = 1'b0;
    fr_a = 0; pw_a = 0; src_a = 0; bimm_a = 0; jt_a = 0; rt_a = 0;
    fr_b = 0; pw_b = 0; src_b = 0; bimm_b = 0; jt_b = 0; rt_b = 0;
    repeat (2) step();

    check("reset pc",       pc_a,              32'h0);
    check("reset pc_plus4", pc4_a,             32'h4);
    check("reset ir",       ir_a,              32'h0);
    check("reset ir_valid", irv_a,             32'h0);
    check("reset busy",     busy_a,            32'h0);
    check("reset fault",    fault_a,           32'h0);
    check("reset rom_rw",   rom_a.rom_rw,      32'h0);
    check("reset rom_addr", rom_a.rom_address, 32'h0);
    rst_n = 1'b1;
    step();

    // Zero-wait fetch at pc 0
    fr_a = 1'b1;
    step();
    fr_a = 1'b0;
    check("fetch0 busy",      busy_a, 32'h1);
    check("fetch0 ir early",  ir_a,   32'h0);
    check("fetch0 irv early", irv_a,  32'h0);
    step();
    check("fetch0 ir",        ir_a,   32'h8C01_0004);
    check("fetch0 irv",       irv_a,  32'h1);
    check("fetch0 busy done", busy_a, 32'h0);
    step();
    check("fetch0 irv pulse", irv_a,  32'h0);
    check("fetch0 ir hold",   ir_a,   32'h8C01_0004);

    // Next-pc sources
    pcw_a(2'b10, 32'h4);
    check("jump to 0x10",    pc_a,              32'h10);
    check("pc_plus4 follow", pc4_a,             32'h14);
    check("rom_addr follow", rom_a.rom_address, 32'h10);
    pcw_a(2'b00, 32'h0);
    check("seq pc+4",        pc_a, 32'h14);
    pcw_a(2'b10, 32'h4);
    pcw_a(2'b01, 32'h0000_FFFE);
    check("branch -2 words", pc_a, 32'h0C);
    pcw_a(2'b10, 32'h20);
    check("jump 0x20",       pc_a, 32'h80);
    pcw_a(2'b11, 32'h40);
    check("reg jump 0x40",   pc_a, 32'h40);

    // pc_write beats fetch_req
    fr_a = 1'b1; src_a = 2'b00; pw_a = 1'b1;
    step();
    fr_a = 1'b0; pw_a = 1'b0;
    check("prio pc",   pc_a,   32'h44);
    check("prio busy", busy_a, 32'h0);
    step();
    check("prio no irv", irv_a, 32'h0);
    check("prio ir",     ir_a,  32'h8C01_0004);

    // Last legal word, then first illegal one
    pcw_a(2'b11, 32'hFC);
    fr_a = 1'b1;
    step();
    fr_a = 1'b0;
    check("fc busy", busy_a, 32'h1);
    step();
    check("fc ir",    ir_a,    32'hFCFD_FEFF);
    check("fc fault", fault_a, 32'h0);
    pcw_a(2'b11, 32'h100);
    fr_a = 1'b1;
    step();
    fr_a = 1'b0;
    check("0x100 fault", fault_a, 32'h1);
    check("0x100 busy",  busy_a,  32'h0);
    step();
    check("0x100 no irv", irv_a, 32'h0);
    check("0x100 ir",     ir_a,  32'hFCFD_FEFF);

    // Fault is sticky; pc_write still works, fetch_req ignored
    pcw_a(2'b11, 32'h8);
    check("sticky pc",    pc_a,    32'h8);
    check("sticky fault", fault_a, 32'h1);
    fr_a = 1'b1;
    step();
    fr_a = 1'b0;
    check("sticky no busy", busy_a, 32'h0);
    step();
    check("sticky no irv", irv_a, 32'h0);

    // Asynchronous reset mid-cycle clears fault
    #2 rst_n = 1'b0;
    #1;
    check("async rst fault", fault_a, 32'h0);
    check("async rst pc",    pc_a,    32'h0);
    check("async rst ir",    ir_a,    32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Misaligned fetch
    pcw_a(2'b11, 32'h102);
    fr_a = 1'b1;
    step();
    fr_a = 1'b0;
    check("misalign fault", fault_a, 32'h1);
    check("misalign busy",  busy_a,  32'h0);
    step();
    check("misalign no irv", irv_a, 32'h0);
    check("misalign ir",     ir_a,  32'h0);

    // Three wait states at pc 8, pc_write during WAIT ignored
    pcw_b(2'b11, 32'h8);
    fr_b = 1'b1;
    step();
    fr_b = 1'b0;
    check("w3 busy k",  busy_b, 32'h1);
    src_b = 2'b00; pw_b = 1'b1;
    step();
    pw_b = 1'b0;
    check("w3 pc held",  pc_b,   32'h8);
    check("w3 busy k1",  busy_b, 32'h1);
    check("w3 ir k1",    ir_b,   32'h0);
    step();
    check("w3 ir k2",    ir_b,   32'h0);
    step();
    check("w3 ir k3",    ir_b,   32'h0);
    check("w3 busy k3",  busy_b, 32'h1);
    step();
    check("w3 ir k4",    ir_b,   32'h0809_0A0B);
    check("w3 irv k4",   irv_b,  32'h1);
    check("w3 busy k4",  busy_b, 32'h0);
    check("w3 pc after", pc_b,   32'h8);
    step();
    check("w3 irv pulse", irv_b, 32'h0);
    check("w3 rom_rw",    rom_b.rom_rw, 32'h0);

    // Reset during WAIT aborts the fetch
    fr_b = 1'b1;
    step();
    fr_b = 1'b0;
    step();
    check("abort busy pre", busy_b, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort busy", busy_b, 32'h0);
    check("abort ir",   ir_b,   32'h0);
    check("abort pc",   pc_b,   32'h0);
    check("abort irv",  irv_b,  32'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("abort no irv", irv_b, 32'h0);
    end
    check("abort ir stays", ir_b, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
